axil_master: RTL and testbench
==============================

# axil_master

Bridges the core's single-outstanding memory request port onto an AXI-Lite master interface. Drives the peripheral side that AXI-Lite slaves such as the GPIO block receive. Each core request is converted into one AXI-Lite write (AW+W+B) or read (AR+R) transaction. Completion and response status are returned to the core as a single-cycle `mem_ready` pulse.

## Interface
- `DATA_WIDTH`, 32, data bus width
- `ADDR_WIDTH`, 32, address width
- `STRB_WIDTH`, DATA_WIDTH/8, write strobe width
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `mem_req`  in  1  request valid; held stable until `mem_ready`
- `mem_we`  in  1  1 = write, 0 = read
- `mem_addr`  in  ADDR_WIDTH  byte address, passed unmodified
- `mem_wdata`  in  DATA_WIDTH  write data
- `mem_wstrb`  in  STRB_WIDTH  byte enables (writes only)
- `mem_ready`  out  1  one-cycle completion pulse
- `mem_rdata`  out  DATA_WIDTH  read data, valid with `mem_ready` on reads
- `mem_err`  out  1  response was SLVERR/DECERR, valid only with `mem_ready`
- `mem_busy`  out  1  high whenever the FSM is not in IDLE
- `m_axil_awaddr`/`awprot`/`awvalid`  out  ADDR_WIDTH/3/1, and `m_axil_awready`  in  1: write address channel
- `m_axil_wdata`/`wstrb`/`wvalid`  out  DATA_WIDTH/STRB_WIDTH/1, and `m_axil_wready`  in  1: write data channel
- `m_axil_bresp`  in  2, `m_axil_bvalid`  in  1, `m_axil_bready`  out  1: write response channel
- `m_axil_araddr`/`arprot`/`arvalid`  out  ADDR_WIDTH/3/1, and `m_axil_arready`  in  1: read address channel
- `m_axil_rdata`  in  DATA_WIDTH, `m_axil_rresp`  in  2, `m_axil_rvalid`  in  1, `m_axil_rready`  out  1: read data channel

## Operation
- FSM states: IDLE, WR (AW/W pending), WR_RESP, RD (AR pending), RD_RESP.
- **IDLE:** accepts a request only when `mem_req=1` and `mem_ready=0`.
  - On acceptance, registers addr, wdata, wstrb and we.
  - `mem_we=1`: goes to WR with `awvalid=wvalid=1`.
  - `mem_we=0`: goes to RD with `arvalid=1`.
- **WR:** `awvalid` clears on its handshake and `wvalid` clears on its handshake, independently; either order or the same cycle is legal.
  - When both handshakes have completed (including both in the same cycle), goes to WR_RESP.
- **WR_RESP:** `bready=1`.
  - On B handshake: `mem_ready=1` next cycle, `mem_err=bresp[1]`, and the FSM returns to IDLE.
- **RD:** `arvalid=1` until AR handshake, then goes to RD_RESP.
- **RD_RESP:** `rready=1`.
  - On R handshake: `mem_rdata<=rdata`, `mem_err=rresp[1]`, `mem_ready=1` next cycle, and the FSM returns to IDLE.
- `awprot`/`arprot` are constant 3'b000. `awaddr`, `araddr`, `wdata` and `wstrb` come from the captured registers and are stable while the corresponding valid is high.
- The block never deasserts a valid before its handshake and never changes payload while a valid is high.
- `mem_rdata` holds its last read value across writes. Error responses still capture `rdata`.
- `mem_req` with `mem_ready=1` (the completion cycle) is ignored, so there is no duplicate issue.
- `bvalid`/`rvalid` arriving while `bready`/`rready` is low are simply left pending; nothing is dropped.

## Timing
- All outputs are registered.
- Reset values: all `m_axil_*valid`, `bready`, `rready`, `mem_ready`, `mem_err` = 0; address, data and strobe registers = 0; `mem_rdata` = 0; state = IDLE; `mem_busy` = 0.
- Reset mid-transaction: the next cycle shows reset values, the in-flight request is discarded, and no `mem_ready` is produced.
- Latency with zero-wait slaves:
  - `mem_req` sampled at edge E0.
  - AW/W or AR valid during cycle 1, handshake at E1.
  - `bready`/`rready` during cycle 2, response handshake at E2.
  - `mem_ready` during cycle 3.
  - Minimum is 3 cycles from request to `mem_ready`; each slave wait cycle adds 1.
- Back-to-back: a new request presented in the cycle after `mem_ready` is accepted at that cycle's edge, giving at most one idle cycle between transactions.
- `mem_busy` is high from the cycle after acceptance through the cycle before `mem_ready`.

## Test plan
- **Zero-wait write:** write `addr=0x1000_0004`, `wdata=0xDEADBEEF`, `wstrb=0xF`, zero-wait slave → AW/W valid in cycle 1 with those values, `bready` in cycle 2, `mem_ready=1` with `mem_err=0` in cycle 3 only.
- **Delayed read:** read `0x2000_0000`; `arready` delayed 3 cycles, `rvalid` 2 cycles after AR, `rdata=0x12345678`, `rresp=0` → `arvalid`/`araddr` held stable 4 cycles; `mem_rdata=0x12345678` and `mem_ready` one cycle after the R handshake.
- **Split write handshakes:** `wready` in cycle 1, `awready` in cycle 4 → `wvalid` low from cycle 2, `awvalid` high through cycle 4, `bready` from cycle 5.
- **Error responses:** write with `bresp=2'b10` → `mem_err=1` with `mem_ready`. Read with `rresp=2'b11` and `rdata=0xBAD0BAD0` → `mem_err=1`, `mem_rdata=0xBAD0BAD0`.
- **Back-to-back:** `mem_req` held through the completion cycle, then a new read presented → exactly one AW/W transaction for the first request, and `arvalid` asserted 2 cycles after `mem_ready`.
- **Reset mid-read:** `rst` asserted for one cycle while in RD_RESP → all outputs at reset values the next cycle, no `mem_ready`, and a subsequent read completes normally.

Source files
------------

// File: rtl/axil_master.sv
// axil_master: bridges a single-outstanding core memory request port onto an AXI-Lite master
module axil_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH/8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [DATA_WIDTH-1:0] mem_wdata_i,
  input  logic [STRB_WIDTH-1:0] mem_wstrb_i,
  output logic                  mem_ready_o,
  output logic [DATA_WIDTH-1:0] mem_rdata_o,
  output logic                  mem_err_o,
  output logic                  mem_busy_o,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr_o,
  output logic [2:0]            m_axil_awprot_o,
  output logic                  m_axil_awvalid_o,
  input  logic                  m_axil_awready_i,
  output logic [DATA_WIDTH-1:0] m_axil_wdata_o,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb_o,
  output logic                  m_axil_wvalid_o,
  input  logic                  m_axil_wready_i,
  input  logic [1:0]            m_axil_bresp_i,
  input  logic                  m_axil_bvalid_i,
  output logic                  m_axil_bready_o,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr_o,
  output logic [2:0]            m_axil_arprot_o,
  output logic                  m_axil_arvalid_o,
  input  logic                  m_axil_arready_i,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata_i,
  input  logic [1:0]            m_axil_rresp_i,
  input  logic                  m_axil_rvalid_i,
  output logic                  m_axil_rready_o
);
  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD, RD_RESP} state_t;
  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
  logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic                    bready_q, bready_d, rready_q, rready_d;
  logic                    ready_q, ready_d, err_q, err_d, busy_q;
  // next-state and registered-output logic; SLVERR/DECERR are the responses with bit 1 set
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    bready_d  = bready_q;
    rready_d  = rready_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: if (mem_req_i && !ready_q) begin
        addr_d    = mem_addr_i;
        wdata_d   = mem_wdata_i;
        wstrb_d   = mem_wstrb_i;
        state_d   = mem_we_i ? WR : RD;
        awvalid_d = mem_we_i;
        wvalid_d  = mem_we_i;
        arvalid_d = !mem_we_i;
      end
      WR: begin
        awvalid_d = awvalid_q && !m_axil_awready_i;
        wvalid_d  = wvalid_q && !m_axil_wready_i;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end
      WR_RESP: if (m_axil_bvalid_i) begin
        state_d  = IDLE;
        bready_d = 1'b0;
        ready_d  = 1'b1;
        err_d    = m_axil_bresp_i >= 2'b10;
      end
      RD: if (m_axil_arready_i) begin
        state_d   = RD_RESP;
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
      end
      RD_RESP: if (m_axil_rvalid_i) begin
        state_d  = IDLE;
        rready_d = 1'b0;
        ready_d  = 1'b1;
        err_d    = m_axil_rresp_i >= 2'b10;
        rdata_d  = m_axil_rdata_i;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers; reset discards any in-flight request
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      bready_q  <= bready_d;
      rready_q  <= rready_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      busy_q    <= state_d != IDLE;
    end
  end
  assign mem_ready_o      = ready_q;
  assign mem_rdata_o      = rdata_q;
  assign mem_err_o        = err_q;
  assign mem_busy_o       = busy_q;
  assign m_axil_awaddr_o  = addr_q;
  assign m_axil_awprot_o  = 3'b000;
  assign m_axil_awvalid_o = awvalid_q;
  assign m_axil_wdata_o   = wdata_q;
  assign m_axil_wstrb_o   = wstrb_q;
  assign m_axil_wvalid_o  = wvalid_q;
  assign m_axil_bready_o  = bready_q;
  assign m_axil_araddr_o  = addr_q;
  assign m_axil_arprot_o  = 3'b000;
  assign m_axil_arvalid_o = arvalid_q;
  assign m_axil_rready_o  = rready_q;
endmodule

// File: tb/tb_axil_master.sv
// tb_axil_master: randomized cycle-level check of axil_master against a timing/payload reference model
module tb_axil_master;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_i, mem_we_i, mem_ready_o, mem_err_o, mem_busy_o;
  logic [31:0] mem_addr_i, mem_wdata_i, mem_rdata_o;
  logic [3:0]  mem_wstrb_i;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] model_rdata = '0;

  axil_master dut (
    .clk(clk), .rst(rst),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_wstrb_i(mem_wstrb_i),
    .mem_ready_o(mem_ready_o), .mem_rdata_o(mem_rdata_o), .mem_err_o(mem_err_o), .mem_busy_o(mem_busy_o),
    .m_axil_awaddr_o(awaddr), .m_axil_awprot_o(awprot), .m_axil_awvalid_o(awvalid), .m_axil_awready_i(awready),
    .m_axil_wdata_o(wdata), .m_axil_wstrb_o(wstrb), .m_axil_wvalid_o(wvalid), .m_axil_wready_i(wready),
    .m_axil_bresp_i(bresp), .m_axil_bvalid_i(bvalid), .m_axil_bready_o(bready),
    .m_axil_araddr_o(araddr), .m_axil_arprot_o(arprot), .m_axil_arvalid_o(arvalid), .m_axil_arready_i(arready),
    .m_axil_rdata_i(rdata), .m_axil_rresp_i(rresp), .m_axil_rvalid_i(rvalid), .m_axil_rready_o(rready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_chk(input string tag);
    chk(tag, {awvalid, wvalid, arvalid, bready, rready, mem_ready_o, mem_busy_o}, 0);
  endtask

  task automatic slave_quiet();
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
    bresp = 2'($urandom); rresp = 2'($urandom); rdata = $urandom;
  endtask

  // One request: a/w = wait cycles before awready/wready (or arready), d = wait before bvalid/rvalid.
  // Expected cycle k (k=1 is the first cycle after acceptance) follows from the handshake arithmetic.
  task automatic txn(input bit we, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                     input int a, input int w, input int d, input logic [1:0] resp, input int gap);
    int s, done;
    cycle();
    idle_chk("no_dup_issue");
    repeat (gap) begin
      mem_req_i = 0;
      cycle();
      idle_chk("gap_idle");
    end
    mem_req_i = 1; mem_we_i = we; mem_addr_i = addr; mem_wdata_i = data; mem_wstrb_i = strb;
    s = we ? 2 + (a > w ? a : w) : 2 + a;
    done = s + d + 1;
    for (int k = 1; k <= done; k++) begin
      cycle();
      chk("awvalid", awvalid, we && k <= 1 + a);
      chk("wvalid", wvalid, we && k <= 1 + w);
      chk("arvalid", arvalid, !we && k <= 1 + a);
      chk("bready", bready, we && k >= s && k <= s + d);
      chk("rready", rready, !we && k >= s && k <= s + d);
      chk("mem_ready", mem_ready_o, k == done);
      chk("mem_busy", mem_busy_o, k < done);
      if (we && k <= 1 + a) chk("awaddr", awaddr, addr);
      if (we && k <= 1 + w) chk("wdata_wstrb", {wstrb, wdata}, {strb, data});
      if (!we && k <= 1 + a) chk("araddr", araddr, addr);
      if (k == done) begin
        if (!we) model_rdata = data;
        chk("mem_err", mem_err_o, resp[1]);
        chk("mem_rdata", mem_rdata_o, model_rdata);
      end
      slave_quiet();
      awready = we && k == 1 + a;
      wready  = we && k == 1 + w;
      arready = !we && k == 1 + a;
      bvalid  = we && k == s + d;
      rvalid  = !we && k == s + d;
      if (bvalid) bresp = resp;
      if (rvalid) begin
        rresp = resp;
        rdata = data;
      end
    end
  endtask

  initial begin
    rst = 1; mem_req_i = 0; mem_we_i = 0; mem_addr_i = 0; mem_wdata_i = 0; mem_wstrb_i = 0;
    slave_quiet();
    repeat (2) cycle();
    idle_chk("rst_ctrl");
    chk("rst_addr_data", {awaddr, araddr}, 0);
    chk("rst_wdata_strb", {wstrb, wdata}, 0);
    chk("rst_rdata_err", {mem_err_o, mem_rdata_o}, 0);
    chk("rst_prot", {awprot, arprot}, 0);
    rst = 0;
    txn(1, 32'h1000_0004, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, 0);
    txn(0, 32'h2000_0000, 32'h12345678, 4'h0, 3, 0, 1, 2'b00, 1);
    txn(1, 32'h3000_0010, 32'hCAFEF00D, 4'h5, 3, 0, 0, 2'b00, 2);
    txn(1, 32'h3000_0014, 32'h0BADF00D, 4'h3, 0, 2, 1, 2'b10, 0);
    txn(0, 32'h4000_0000, 32'hBAD0BAD0, 4'h0, 1, 0, 0, 2'b11, 0);
    txn(1, 32'h5000_0000, 32'h11112222, 4'hC, 0, 0, 0, 2'b00, 0);
    txn(0, 32'h5000_0004, 32'h33334444, 4'h0, 0, 0, 0, 2'b00, 0);
    // reset while waiting in RD_RESP
    cycle();
    idle_chk("pre_rst_read");
    mem_req_i = 1; mem_we_i = 0; mem_addr_i = 32'h6000_0008;
    cycle();
    chk("rst_test_arvalid", arvalid, 1);
    slave_quiet();
    arready = 1;
    cycle();
    chk("rst_test_rready", rready, 1);
    slave_quiet();
    rst = 1; mem_req_i = 0;
    cycle();
    idle_chk("midrst_ctrl");
    chk("midrst_regs", {mem_err_o, mem_rdata_o, araddr}, 0);
    rst = 0;
    model_rdata = '0;
    repeat (3) begin
      cycle();
      idle_chk("post_rst_quiet");
    end
    txn(0, 32'h6000_0008, 32'h55AA55AA, 4'h0, 0, 0, 0, 2'b00, 0);
    for (int i = 0; i < 40; i++)
      txn(1'($urandom), $urandom, $urandom, 4'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)), 2'($urandom), int'($urandom_range(0, 2)));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
